// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns the async FIFO pop port (rempty/rinc, data one cycle later) into a registered valid/ready stream.
// Latency: pop issued in cycle N, word captured at end of N+1, presented on m_valid/m_data in N+2.
// Backpressure: pops stop once every buffer slot is occupied or reserved; m_valid/m_data hold while m_ready is low.
//
// Ports:
//   rclk      read-domain clock
//   rst       asynchronous active-high reset, asserted together with the FIFO reset
//   f_rempty  FIFO empty flag (registered inside the FIFO)
//   f_rinc    FIFO pop request
//   f_rdata   FIFO read data, valid the cycle after an accepted pop
//   m_valid   output word valid
//   m_ready   downstream accepts m_data
//   m_data    output word (buffer head)
//   level     buffered words, not counting a pop still in flight
module fifo_rd_stream #(
  parameter  int WIDTH     = 32,
  parameter  int BUF_DEPTH = 3,
  localparam int LVL_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             f_rempty,
  output logic             f_rinc,
  input  logic [WIDTH-1:0] f_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [LVL_W-1:0] level
);

  localparam int               PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [LVL_W:0]   DEPTH_W  = (LVL_W + 1)'(BUF_DEPTH);

  logic [WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             inflight_q;

  logic             capture;
  logic             consume;
  logic [LVL_W:0]   reserved;

  // Circular pointer increment, wrapping at BUF_DEPTH-1 (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Slots already holding data plus the slot promised to the pop in flight.
  // Issuing only when one is free means captured data never overwrites a live entry.
  // The decision uses registered state only, so m_ready has no path to f_rinc.
  assign reserved = {1'b0, level_q} + {{LVL_W{1'b0}}, inflight_q};
  assign f_rinc   = ~rst & ~f_rempty & (reserved < DEPTH_W);

  // FIFO data arrives exactly one cycle after an accepted pop.
  assign capture  = inflight_q;
  assign m_valid  = (level_q != '0);
  assign consume  = m_valid & m_ready;
  assign m_data   = buf_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (capture) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (consume) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    // A simultaneous capture and consume leaves the occupancy unchanged.
    if (capture && !consume) begin
      level_d = level_q + LVL_W'(1);
    end else if (!capture && consume) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      inflight_q <= f_rinc;
      if (capture) begin
        buf_q[wr_ptr_q] <= f_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, a queue-based
// buffer model predicts the stream, and each scenario task compares the DUT to it.
module tb_fifo_rd_stream;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int LVL_W = 2;

  logic             rclk;
  logic             rst;
  logic             f_rempty;
  logic             f_rinc;
  logic [WIDTH-1:0] f_rdata;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [LVL_W-1:0] level;

  fifo_rd_stream #(.WIDTH(WIDTH), .BUF_DEPTH(DEPTH)) dut (
    .rclk    (rclk),
    .rst     (rst),
    .f_rempty(f_rempty),
    .f_rinc  (f_rinc),
    .f_rdata (f_rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: fq = words still in the FIFO, mq = words held in the
  // prefetch buffer (head first), plus one in-flight word.
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sent[$];
  logic [WIDTH-1:0] got[$];
  bit               m_infl;
  logic [WIDTH-1:0] m_infl_word;
  int               gap_pct;

  bit               exp_rinc;
  bit               exp_valid;
  logic [LVL_W-1:0] exp_level;
  logic [WIDTH-1:0] exp_data;
  logic [WIDTH-1:0] obs_data;

  // Called between edges: what the DUT should be showing now.
  task automatic model_expect();
    if (rst) begin
      exp_rinc  = 1'b0;
      exp_valid = 1'b0;
      exp_level = '0;
      exp_data  = '0;
    end else begin
      exp_rinc  = !f_rempty && (mq.size() + int'(m_infl) < DEPTH);
      exp_valid = (mq.size() != 0);
      exp_level = LVL_W'(mq.size());
      exp_data  = exp_valid ? mq[0] : '0;
    end
    obs_data = m_data;
  endtask

  // Called at the rising edge: advance the model, then drive the FIFO side.
  task automatic model_advance();
    if (rst) begin
      mq.delete();
      m_infl = 1'b0;
    end else begin
      if (exp_valid && m_ready) begin
        void'(mq.pop_front());
        got.push_back(obs_data);
      end
      if (m_infl) mq.push_back(m_infl_word);
      m_infl = exp_rinc;
      if (exp_rinc && fq.size() != 0) m_infl_word = fq.pop_front();
    end
    #1;
    f_rdata  = (m_infl && !rst) ? m_infl_word : WIDTH'($urandom);
    f_rempty = (fq.size() == 0) || ($urandom_range(0, 99) < gap_pct);
  endtask

  task automatic load_words(input logic [WIDTH-1:0] base, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [WIDTH-1:0] w;
      w = rnd ? WIDTH'($urandom) : base + WIDTH'(i);
      fq.push_back(w);
      sent.push_back(w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f_rempty = 1'b0;
      @(negedge rclk);
      checks++; if (f_rinc !== 1'b0) begin failures++; $display("FAIL reset_rinc k=%0d got=%b exp=0", k, f_rinc); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid k=%0d got=%b exp=0", k, m_valid); end
      checks++; if (level !== '0) begin failures++; $display("FAIL reset_level k=%0d got=%0d exp=0", k, level); end
      checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_data k=%0d got=%h exp=0", k, m_data); end
      @(posedge rclk);
      model_advance();
    end
    f_rempty = 1'b1;
    @(negedge rclk);
    rst = 1'b0;
    model_expect();
    @(posedge rclk);
    model_advance();
  endtask

  task automatic test_single_word();
    sent.delete(); got.delete();
    gap_pct = 0;
    m_ready = 1'b1;
    load_words(32'hA5A5_0001, 1, 1'b0);
    f_rempty = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge rclk);
      model_expect();
      checks++; if (f_rinc !== (k == 0)) begin failures++; $display("FAIL single_rinc k=%0d got=%b exp=%b", k, f_rinc, k == 0); end
      checks++; if (m_valid !== (k == 2)) begin failures++; $display("FAIL single_valid k=%0d got=%b exp=%b", k, m_valid, k == 2); end
      if (k == 2) begin
        checks++; if (m_data !== 32'hA5A5_0001) begin failures++; $display("FAIL single_data got=%h exp=a5a50001", m_data); end
      end
      @(posedge rclk);
      model_advance();
    end
  endtask

  task automatic test_streaming();
    int c, first_c, last_c;
    sent.delete(); got.delete();
    gap_pct = 0;
    m_ready = 1'b1;
    load_words(0, 8, 1'b0);
    f_rempty = 1'b0;
    c = 0; first_c = -1; last_c = -1;
    while (got.size() < 8 && c < 40) begin
      @(negedge rclk);
      model_expect();
      checks++; if (f_rinc !== exp_rinc) begin failures++; $display("FAIL stream_rinc c=%0d got=%b exp=%b", c, f_rinc, exp_rinc); end
      checks++; if (m_valid !== exp_valid) begin failures++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, m_valid, exp_valid); end
      checks++; if (level !== exp_level) begin failures++; $display("FAIL stream_level c=%0d got=%0d exp=%0d", c, level, exp_level); end
      if (exp_valid) begin
        checks++; if (m_data !== exp_data) begin failures++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, m_data, exp_data); end
      end
      if (m_valid && m_ready) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      @(posedge rclk);
      model_advance();
      c++;
    end
    checks++; if (got.size() != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== WIDTH'(i)) begin failures++; $display("FAIL stream_order i=%0d got=%h exp=%h", i, got[i], i); end
    end
    checks++; if (last_c - first_c !== 7) begin failures++; $display("FAIL stream_gapless span=%0d exp=7", last_c - first_c); end
  endtask

  task automatic test_backpressure();
    int pops;
    sent.delete(); got.delete();
    gap_pct = 0;
    m_ready = 1'b0;
    load_words(0, 10, 1'b0);
    f_rempty = 1'b0;
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      model_expect();
      checks++; if (f_rinc !== exp_rinc) begin failures++; $display("FAIL bp_rinc c=%0d got=%b exp=%b", c, f_rinc, exp_rinc); end
      checks++; if (level !== exp_level) begin failures++; $display("FAIL bp_level c=%0d got=%0d exp=%0d", c, level, exp_level); end
      if (f_rinc) pops++;
      @(posedge rclk);
      model_advance();
    end
    @(negedge rclk);
    checks++; if (pops !== 3) begin failures++; $display("FAIL bp_pops got=%0d exp=3", pops); end
    checks++; if (level !== 2'd3) begin failures++; $display("FAIL bp_full_level got=%0d exp=3", level); end
    checks++; if (m_valid !== 1'b1 || m_data !== '0) begin failures++; $display("FAIL bp_hold valid=%b data=%h exp valid=1 data=0", m_valid, m_data); end
    @(posedge rclk);
    model_expect();
    model_advance();
    m_ready = 1'b1;
    for (int c = 0; c < 60 && got.size() < 10; c++) begin
      @(negedge rclk);
      model_expect();
      checks++; if (m_valid !== exp_valid) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, m_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (m_data !== exp_data) begin failures++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, m_data, exp_data); end
      end
      @(posedge rclk);
      model_advance();
    end
    checks++; if (got.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++; if (got[i] !== WIDTH'(i)) begin failures++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, got[i], i); end
    end
  endtask

  task automatic test_random_wrap();
    int c;
    sent.delete(); got.delete();
    gap_pct = 30;
    load_words(0, 200, 1'b1);
    f_rempty = 1'b0;
    m_ready = 1'($urandom_range(0, 1));
    c = 0;
    while (got.size() < 200 && c < 3000) begin
      @(negedge rclk);
      model_expect();
      checks++; if (f_rinc !== exp_rinc) begin failures++; $display("FAIL rnd_rinc c=%0d got=%b exp=%b", c, f_rinc, exp_rinc); end
      checks++; if ((f_rinc & f_rempty) !== 1'b0) begin failures++; $display("FAIL rnd_pop_empty c=%0d rinc=%b rempty=%b", c, f_rinc, f_rempty); end
      checks++; if (m_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, m_valid, exp_valid); end
      checks++; if (level !== exp_level) begin failures++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, exp_level); end
      if (exp_valid) begin
        checks++; if (m_data !== exp_data) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, m_data, exp_data); end
      end
      @(posedge rclk);
      model_advance();
      m_ready = 1'($urandom_range(0, 1));
      c++;
    end
    checks++; if (got.size() != 200) begin failures++; $display("FAIL rnd_count got=%0d exp=200", got.size()); end
    for (int i = 0; i < got.size() && i < 200; i++) begin
      checks++; if (got[i] !== sent[i]) begin failures++; $display("FAIL rnd_order i=%0d got=%h exp=%h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_midstream_reset();
    bit hit;
    sent.delete(); got.delete();
    gap_pct = 0;
    m_ready = 1'b0;
    load_words(32'h50, 10, 1'b0);
    f_rempty = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge rclk);
      model_expect();
      if (exp_level == 2 && m_infl) begin
        hit = 1'b1;
      end else begin
        @(posedge rclk);
        model_advance();
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL mrst_reach level=%0d never reached level=2 inflight=1", level); end
    checks++; if (level !== 2'd2) begin failures++; $display("FAIL mrst_pre_level got=%0d exp=2", level); end
    #2;
    rst = 1'b1;
    fq.delete();
    f_rempty = 1'b1;
    #1;
    checks++; if (f_rinc !== 1'b0) begin failures++; $display("FAIL mrst_rinc got=%b exp=0", f_rinc); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", m_valid); end
    checks++; if (level !== '0) begin failures++; $display("FAIL mrst_level got=%0d exp=0", level); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL mrst_data got=%h exp=0", m_data); end
    for (int c = 0; c < 2; c++) begin
      @(posedge rclk);
      model_advance();
    end
    @(negedge rclk);
    rst = 1'b0;
    sent.delete(); got.delete();
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge rclk);
      model_expect();
      checks++; if (f_rinc !== 1'b0) begin failures++; $display("FAIL mrst_idle_rinc c=%0d got=%b exp=0", c, f_rinc); end
      @(posedge rclk);
      model_advance();
    end
    load_words(32'h100, 8, 1'b0);
    f_rempty = 1'b0;
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      @(negedge rclk);
      model_expect();
      checks++; if (f_rinc !== exp_rinc) begin failures++; $display("FAIL mrst_rinc2 c=%0d got=%b exp=%b", c, f_rinc, exp_rinc); end
      checks++; if (m_valid !== exp_valid) begin failures++; $display("FAIL mrst_valid2 c=%0d got=%b exp=%b", c, m_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (m_data !== exp_data) begin failures++; $display("FAIL mrst_data2 c=%0d got=%h exp=%h", c, m_data, exp_data); end
      end
      @(posedge rclk);
      model_advance();
    end
    checks++; if (got.size() != 8) begin failures++; $display("FAIL mrst_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== 32'h100 + WIDTH'(i)) begin failures++; $display("FAIL mrst_order i=%0d got=%h exp=%h", i, got[i], 32'h100 + i); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    f_rempty    = 1'b1;
    f_rdata     = '0;
    m_ready     = 1'b0;
    m_infl      = 1'b0;
    m_infl_word = '0;
    gap_pct     = 0;
    exp_rinc    = 1'b0;
    exp_valid   = 1'b0;
    exp_level   = '0;
    exp_data    = '0;
    obs_data    = '0;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_random_wrap();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
